rom_line_arbiter: RTL and testbench

Arbitrates line-refill requests from the instruction cache and the data cache onto the single shared boot/program ROM port. The arbiter issues one line read at a time, waits for the ROM's output-enable, registers the returned line and acknowledges the granted requester. It sits between the two cache refill engines and the `rom` instance, owns every `re` pulse the ROM sees, and flags a sticky error if the ROM never answers.

---
 rtl/rom_line_arbiter.sv | 133 +++++++++++++
 tb/tb_rom_line_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_line_arbiter.sv
// Arbitrates I-cache and D-cache line refills onto the shared ROM port, one line read at a time.
// Define ROM_ARB_RR_EN for round-robin tie-breaking; the default build gives the I-port priority.
module rom_line_arbiter #(
   parameter int unsigned ROM_DELAY           = 5,
   parameter int unsigned TIMEOUT             = 15,
   parameter int unsigned CACHE_WORD_ADR_SIZE = 2,
   parameter int unsigned LINE_WORDS          = 2**CACHE_WORD_ADR_SIZE
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_req,
   input  logic [31:0]                 i_addr,
   output logic                        i_ack,
   input  logic                        d_req,
   input  logic [31:0]                 d_addr,
   output logic                        d_ack,
   output logic [LINE_WORDS-1:0][31:0] line_data,
   output logic [31:0]                 rom_addr,
   output logic                        rom_re,
   input  logic [LINE_WORDS-1:0][31:0] rom_data,
   input  logic                        rom_oe,
   output logic                        busy,
   output logic                        timeout_err
);

   localparam int unsigned HoldCycles = ROM_DELAY + 2;
   localparam int unsigned CntMax     = (TIMEOUT > HoldCycles) ? TIMEOUT : HoldCycles;
   localparam int unsigned CntW       = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
   localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT - 1);
   localparam logic [31:0]     LineMask = 32'hFFFF_FFFF << (CACHE_WORD_ADR_SIZE + 2);

   typedef enum logic [2:0] {StHoldoff, StIdle, StIssue, StWait, StResp} state_e;

   state_e                      state_q, state_d;
   logic [CntW-1:0]             cnt_q, cnt_d;
   logic                        sel_q, sel_d;    // 1: D-port granted
   logic [31:0]                 addr_q, addr_d;
   logic [LINE_WORDS-1:0][31:0] line_q, line_d;
   logic                        err_q, err_d;
`ifdef ROM_ARB_RR_EN
   logic                        last_q, last_d;  // 1: D-port was granted last
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StHoldoff;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         addr_q  <= '0;
         line_q  <= '0;
         err_q   <= 1'b0;
`ifdef ROM_ARB_RR_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         line_q  <= line_d;
         err_q   <= err_d;
`ifdef ROM_ARB_RR_EN
         last_q  <= last_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      line_d  = line_q;
      err_d   = err_q;
`ifdef ROM_ARB_RR_EN
      last_d  = last_q;
`endif
      unique case (state_q)
         // A read issued before reset may still be in flight inside the ROM; let it drain.
         StHoldoff: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == HoldLast) begin
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (i_req || d_req) begin
`ifdef ROM_ARB_RR_EN
               sel_d = d_req && (!i_req || !last_q);
`else
               sel_d = !i_req;
`endif
               addr_d  = (sel_d ? d_addr : i_addr) & LineMask;
               state_d = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            if (rom_oe) begin
               line_d  = rom_data;
               state_d = StResp;
            end else if (cnt_q == WaitLast) begin
               line_d  = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
`ifdef ROM_ARB_RR_EN
            last_d  = sel_q;
`endif
            state_d = StIdle;
         end
         default: state_d = StHoldoff;
      endcase
   end

   assign i_ack       = (state_q == StResp) && !sel_q;
   assign d_ack       = (state_q == StResp) && sel_q;
   assign rom_re      = (state_q == StIssue);
   assign rom_addr    = addr_q;
   assign line_data   = line_q;
   assign timeout_err = err_q;
   // The state register sits in HOLDOFF during reset, so busy is masked to read 0 while rst is high.
   assign busy        = !rst && (state_q != StIdle);

endmodule

// File: tb/tb_rom_line_arbiter.sv
// Directed, scoreboard-checked bench for rom_line_arbiter with a behavioural ROM model.
module tb_rom_line_arbiter;

   localparam int unsigned RomDelay = 5;
   localparam int unsigned Lw       = 4;
`ifdef ROM_ARB_RR_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   typedef logic [Lw-1:0][31:0] line_t;
   typedef struct {
      logic  is_d;
      int    at;
      line_t line;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req;
   logic [31:0] i_addr, d_addr;
   logic        i_ack, d_ack;
   line_t       line_data, rom_data;
   logic [31:0] rom_addr;
   logic        rom_re, rom_oe, busy, timeout_err;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   rom_line_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .i_req       (i_req),
      .i_addr      (i_addr),
      .i_ack       (i_ack),
      .d_req       (d_req),
      .d_addr      (d_addr),
      .d_ack       (d_ack),
      .line_data   (line_data),
      .rom_addr    (rom_addr),
      .rom_re      (rom_re),
      .rom_data    (rom_data),
      .rom_oe      (rom_oe),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM model: line valid ROM_DELAY+2 cycles after the re cycle; no reset.
   logic        model_en = 1'b1;
   logic        model_oe = 1'b0;
   logic        stray_oe = 1'b0;
   logic        use_fixed = 1'b0;
   line_t       fixed_line;
   int          cd = 0;
   int          re_cnt = 0;
   logic [31:0] re_addr = '0;

   function automatic line_t gen_line(input logic [31:0] a);
      line_t l;
      for (int k = 0; k < Lw; k++) l[k] = a ^ (32'hA5A5_0000 | 32'(k));
      return l;
   endfunction

   always @(negedge clk) begin
      model_oe <= 1'b0;
      if (cd > 0) begin
         cd <= cd - 1;
         if (cd == 1 && model_en) model_oe <= 1'b1;
      end
      if (rom_re) begin
         cd      <= RomDelay + 2;
         re_cnt  <= re_cnt + 1;
         re_addr <= rom_addr;
      end
   end

   assign rom_oe   = model_oe | stray_oe;
   assign rom_data = use_fixed ? fixed_line : gen_line(rom_addr);

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 60) begin
         step();
         n++;
      end
      check({tag, "_idle"}, busy, 1'b0);
   endtask

   // Raise the requests in an IDLE cycle, expect one ack, then drop both requests.
   task automatic serve(input logic ri, input logic rd, input logic [31:0] ia,
                        input logic [31:0] da, input logic exp_d, input int lat,
                        input line_t exp_line, input string tag);
      int   t;
      exp_t e;
      bit   got = 1'b0;
      wait_idle(tag);
      t      = cyc;
      i_req  = ri;
      d_req  = rd;
      i_addr = ia;
      d_addr = da;
      sb.push_back('{exp_d, t + lat, exp_line});
      for (int n = 0; n < 40 && !got; n++) begin
         step();
         if (i_ack || d_ack) begin
            e = sb.pop_front();
            check({tag, "_port"}, {i_ack, d_ack}, e.is_d ? 2'b01 : 2'b10);
            check({tag, "_cycle"}, cyc, e.at);
            check({tag, "_line"}, line_data, e.line);
            got = 1'b1;
         end
      end
      check({tag, "_ack_seen"}, got, 1'b1);
      if (!got) sb.delete();
      i_req = 1'b0;
      d_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int    r0, t;
      logic  wd;
      line_t held;
      rst = 1'b1;
      i_req = 1'b0;
      d_req = 1'b0;
      i_addr = '0;
      d_addr = '0;
      fixed_line = {32'h11, 32'h22, 32'h33, 32'h44};
      step();
      step();
      check("rst_busy", busy, 1'b0);
      check("rst_acks", {i_ack, d_ack}, 2'b00);
      check("rst_re", rom_re, 1'b0);
      check("rst_addr", rom_addr, 32'h0);
      check("rst_line", line_data, '0);
      check("rst_err", timeout_err, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < RomDelay + 1; k++) step();
      check("holdoff_busy", busy, 1'b1);

      // Ties: fixed priority gives I,I,I; round-robin gives I,D,I.
      for (int r = 0; r < 3; r++) begin
         wd = RrEn && (r == 1);
         serve(1'b1, 1'b1, 32'h1008 + 32'(r * 64), 32'h200C + 32'(r * 64), wd, 9,
               gen_line(wd ? 32'h2000 + 32'(r * 64) : 32'h1000 + 32'(r * 64)),
               $sformatf("tie%0d", r));
      end

      // Single I-request with a fixed ROM line.
      use_fixed = 1'b1;
      wait_idle("single_pre");
      r0 = re_cnt;
      serve(1'b1, 1'b0, 32'h0000_0034, 32'h0, 1'b0, 9, fixed_line, "single");
      check("single_re_cnt", re_cnt - r0, 1);
      check("single_re_addr", re_addr, 32'h0000_0030);

      // Stray rom_oe while IDLE.
      wait_idle("stray");
      stray_oe = 1'b1;
      step();
      stray_oe = 1'b0;
      check("stray_ack0", {i_ack, d_ack}, 2'b00);
      step();
      check("stray_ack1", {i_ack, d_ack}, 2'b00);
      step();
      check("stray_line", line_data, fixed_line);
      check("stray_busy", busy, 1'b0);
      use_fixed = 1'b0;

      // ROM never answers.
      check("pre_to_err", timeout_err, 1'b0);
      model_en = 1'b0;
      serve(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 17, '0, "timeout");
      check("to_err", timeout_err, 1'b1);
      model_en = 1'b1;
      serve(1'b0, 1'b1, 32'h0, 32'h0000_0204, 1'b1, 9, gen_line(32'h0000_0200), "after_to");
      check("to_err_sticky", timeout_err, 1'b1);

      // Reset in WAIT; the late rom_oe lands in HOLDOFF.
      wait_idle("rstwait");
      i_req  = 1'b1;
      i_addr = 32'h0000_0340;
      for (int k = 0; k < 4; k++) step();
      check("rw_busy_wait", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("rw_busy", busy, 1'b0);
      check("rw_acks", {i_ack, d_ack}, 2'b00);
      check("rw_addr", rom_addr, 32'h0);
      check("rw_line", line_data, '0);
      check("rw_err", timeout_err, 1'b0);
      i_req = 1'b0;
      step();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         check("rw_hold_busy", busy, 1'b1);
         check("rw_hold_ack", {i_ack, d_ack}, 2'b00);
         check("rw_hold_line", line_data, '0);
      end
      serve(1'b1, 1'b0, 32'h0000_0554, 32'h0, 1'b0, 9, gen_line(32'h0000_0550), "post_rst");

      // D request held for 100 cycles: an ack every 10 cycles, one re per request.
      wait_idle("dhold");
      r0     = re_cnt;
      t      = cyc;
      d_req  = 1'b1;
      d_addr = 32'h0000_0408;
      for (int k = 0; k < 100; k++) begin
         check("dhold_ack", {i_ack, d_ack}, {1'b0, (k % 10) == 9});
         step();
      end
      check("dhold_cycles", cyc - t, 100);
      d_req = 1'b0;
      for (int k = 0; k < 12; k++) step();
      check("dhold_re_cnt", re_cnt - r0, 10);
      check("dhold_line", line_data, gen_line(32'h0000_0400));
      check("dhold_idle", busy, 1'b0);
      check("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
